my_axi4_lite_mst: RTL and testbench

Single-outstanding AXI4-Lite master that turns a simple valid/ready command (one read or one write) into a complete AXI4-Lite transaction and returns the response on a valid/ready response port. It is the initiator counterpart of the team's AXI4-Lite register slaves. It drives register-map slaves from sequencers, CPU-less control logic and UVM register-model benches.

---
 rtl/my_axi4_lite_pkg.sv | 33 +++
 rtl/axi4_lite_if.sv | 37 +++
 rtl/my_axi4_lite_mst_wdt.sv | 27 ++
 rtl/my_axi4_lite_mst.sv | 187 ++++++++++++++++++
 tb/tb_my_axi4_lite_mst.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/my_axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, master FSM states and the command record.
package my_axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi4_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } mst_state_t;

  // Sized for the widest supported bus; narrower users take the low bits.
  localparam int CMD_ADDR_MAX = 32;
  localparam int CMD_DATA_MAX = 64;

  typedef struct packed {
    logic                      is_wr;
    logic [CMD_ADDR_MAX-1:0]   addr;
    logic [CMD_DATA_MAX-1:0]   wdata;
    logic [CMD_DATA_MAX/8-1:0] wstrb;
  } cmd_t;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH = 32
);
  logic                        awvalid;
  logic                        awready;
  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        wvalid;
  logic                        wready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        bvalid;
  logic                        bready;
  logic [1:0]                  bresp;
  logic                        arvalid;
  logic                        arready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        rvalid;
  logic                        rready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;

  modport mst_port (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slv_port (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/my_axi4_lite_mst_wdt.sv
// Saturating watchdog for the AXI4-Lite master; built only with MY_AXI4_LITE_MST_TIMEOUT_EN.
`ifdef MY_AXI4_LITE_MST_TIMEOUT_EN
module my_axi4_lite_mst_wdt #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable && count != CNT_W'(LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the edge that brings the count to LIMIT.
  assign expired = enable && (count == CNT_W'(LIMIT - 1));
endmodule
`endif

// File: rtl/my_axi4_lite_mst.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction, one response out.
// Optional watchdog abort enabled by defining MY_AXI4_LITE_MST_TIMEOUT_EN.
module my_axi4_lite_mst
  import my_axi4_lite_pkg::*;
#(
  parameter int ADDR_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        i_clk,
  input  logic                        i_sync_rst_n,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_is_wr,
  input  logic [ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                  o_rsp_resp,
  output logic                        o_rsp_timeout,
  axi4_lite_if.mst_port               if_m_axi4_lite
);

  if ($bits(if_m_axi4_lite.awaddr) != ADDR_BIT_WIDTH) begin : g_bad_addr_w
    $error("my_axi4_lite_mst: ADDR_BIT_WIDTH differs from the interface");
  end
  if ($bits(if_m_axi4_lite.wdata) != DATA_BIT_WIDTH) begin : g_bad_data_w
    $error("my_axi4_lite_mst: DATA_BIT_WIDTH differs from the interface");
  end
  if (DATA_BIT_WIDTH != 32 && DATA_BIT_WIDTH != 64) begin : g_bad_data_sz
    $error("my_axi4_lite_mst: DATA_BIT_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("my_axi4_lite_mst: TIMEOUT_CYCLES must be at least 2");
  end

  mst_state_t state;
  logic       aw_pend;
  logic       w_pend;

  assign o_cmd_ready            = (state == IDLE);
  assign if_m_axi4_lite.awprot  = AXI_PROT_DEFAULT;
  assign if_m_axi4_lite.arprot  = AXI_PROT_DEFAULT;
  assign aw_pend = if_m_axi4_lite.awvalid && !if_m_axi4_lite.awready;
  assign w_pend  = if_m_axi4_lite.wvalid  && !if_m_axi4_lite.wready;

`ifdef MY_AXI4_LITE_MST_TIMEOUT_EN
  logic wdt_expired;
  logic hs_done;
  logic busy;
  logic rsp_timeout_q;

  assign busy = (state == WR_REQ) || (state == WR_RESP) ||
                (state == RD_REQ) || (state == RD_DATA);

  my_axi4_lite_mst_wdt #(.LIMIT(TIMEOUT_CYCLES)) u_wdt (
    .clk     (i_clk),
    .rst_n   (i_sync_rst_n),
    .clear   (state == IDLE),
    .enable  (busy),
    .expired (wdt_expired)
  );

  // Completion of the current phase overrides an expiry on the same edge.
  always_comb begin
    // NOTE: default first so no path leaves hs_done unassigned (no latch).
    hs_done = 1'b0;
    unique case (state)
      WR_REQ:  hs_done = !aw_pend && !w_pend;
      WR_RESP: hs_done = if_m_axi4_lite.bvalid;
      RD_REQ:  hs_done = if_m_axi4_lite.arready;
      RD_DATA: hs_done = if_m_axi4_lite.rvalid;
      default: hs_done = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) begin
      rsp_timeout_q <= 1'b0;
    end else if (wdt_expired && !hs_done) begin
      rsp_timeout_q <= 1'b1;
    end else if (state == RSP && i_rsp_ready) begin
      rsp_timeout_q <= 1'b0;
    end
  end

  assign o_rsp_timeout = rsp_timeout_q;
`else
  assign o_rsp_timeout = 1'b0;
`endif

  // NOTE: state and registered outputs use non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) begin
      state                  <= IDLE;
      if_m_axi4_lite.awvalid <= 1'b0;
      if_m_axi4_lite.wvalid  <= 1'b0;
      if_m_axi4_lite.bready  <= 1'b0;
      if_m_axi4_lite.arvalid <= 1'b0;
      if_m_axi4_lite.rready  <= 1'b0;
      if_m_axi4_lite.awaddr  <= '0;
      if_m_axi4_lite.wdata   <= '0;
      if_m_axi4_lite.wstrb   <= '0;
      if_m_axi4_lite.araddr  <= '0;
      o_rsp_valid            <= 1'b0;
      o_rsp_rdata            <= '0;
      o_rsp_resp             <= RESP_OKAY;
    end
`ifdef MY_AXI4_LITE_MST_TIMEOUT_EN
    else if (wdt_expired && !hs_done) begin
      if_m_axi4_lite.awvalid <= 1'b0;
      if_m_axi4_lite.wvalid  <= 1'b0;
      if_m_axi4_lite.bready  <= 1'b0;
      if_m_axi4_lite.arvalid <= 1'b0;
      if_m_axi4_lite.rready  <= 1'b0;
      o_rsp_valid            <= 1'b1;
      o_rsp_rdata            <= '0;
      o_rsp_resp             <= RESP_DECERR;
      state                  <= RSP;
    end
`endif
    else begin
      unique case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            if (i_cmd_is_wr) begin
              if_m_axi4_lite.awvalid <= 1'b1;
              if_m_axi4_lite.wvalid  <= 1'b1;
              if_m_axi4_lite.awaddr  <= i_cmd_addr;
              if_m_axi4_lite.wdata   <= i_cmd_wdata;
              if_m_axi4_lite.wstrb   <= i_cmd_wstrb;
              state                  <= WR_REQ;
            end else begin
              if_m_axi4_lite.arvalid <= 1'b1;
              if_m_axi4_lite.araddr  <= i_cmd_addr;
              state                  <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          // AW and W retire independently, in either order.
          if (if_m_axi4_lite.awvalid && if_m_axi4_lite.awready) if_m_axi4_lite.awvalid <= 1'b0;
          if (if_m_axi4_lite.wvalid && if_m_axi4_lite.wready)   if_m_axi4_lite.wvalid  <= 1'b0;
          if (!aw_pend && !w_pend) begin
            if_m_axi4_lite.bready <= 1'b1;
            state                 <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (if_m_axi4_lite.bvalid) begin
            if_m_axi4_lite.bready <= 1'b0;
            o_rsp_resp            <= if_m_axi4_lite.bresp;
            o_rsp_rdata           <= '0;
            o_rsp_valid           <= 1'b1;
            state                 <= RSP;
          end
        end
        RD_REQ: begin
          if (if_m_axi4_lite.arready) begin
            if_m_axi4_lite.arvalid <= 1'b0;
            if_m_axi4_lite.rready  <= 1'b1;
            state                  <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (if_m_axi4_lite.rvalid) begin
            if_m_axi4_lite.rready <= 1'b0;
            o_rsp_resp            <= if_m_axi4_lite.rresp;
            o_rsp_rdata           <= if_m_axi4_lite.rdata;
            o_rsp_valid           <= 1'b1;
            state                 <= RSP;
          end
        end
        RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_my_axi4_lite_mst.sv
// Directed bench for my_axi4_lite_mst with a delay-configurable AXI4-Lite slave model.
`timescale 1ns/1ps
module tb_my_axi4_lite_mst;
  import my_axi4_lite_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_is_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW/8-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;

  int n_chk = 0;
  int n_fail = 0;

  axi4_lite_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) axi ();

  my_axi4_lite_mst #(
    .ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk         (clk),
    .i_sync_rst_n  (rst_n),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_is_wr   (cmd_is_wr),
    .i_cmd_addr    (cmd_addr),
    .i_cmd_wdata   (cmd_wdata),
    .i_cmd_wstrb   (cmd_wstrb),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_rdata   (rsp_rdata),
    .o_rsp_resp    (rsp_resp),
    .o_rsp_timeout (rsp_timeout),
    .if_m_axi4_lite(axi)
  );

  always #5 clk = ~clk;

  // ---------------- slave model: words at 0x0/0x4/0x8, 0xC unmapped ----------------
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  bit ar_never = 1'b0;
  int aw_cnt, w_cnt, ar_cnt, r_cnt;
  logic aw_got, w_got, ar_got;
  logic [AW-1:0] aw_addr_q, ar_addr_q;
  logic [DW-1:0] w_data_q;
  logic [DW/8-1:0] w_strb_q;
  logic [DW-1:0] mem [4];
  int wr_count = 0;

  function automatic logic mapped(input logic [AW-1:0] a);
    return a < 4'hC;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      axi.awready <= 1'b0; axi.wready <= 1'b0; axi.bvalid <= 1'b0;
      axi.arready <= 1'b0; axi.rvalid <= 1'b0;
      axi.bresp <= 2'b00; axi.rresp <= 2'b00; axi.rdata <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
    end else begin
      if (axi.awvalid && axi.awready) begin
        aw_got <= 1'b1; aw_addr_q <= axi.awaddr; axi.awready <= (aw_dly == 0); aw_cnt <= 0;
      end else if (axi.awvalid) begin
        if (aw_cnt + 1 >= aw_dly) axi.awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
      end else axi.awready <= (aw_dly == 0);

      if (axi.wvalid && axi.wready) begin
        w_got <= 1'b1; w_data_q <= axi.wdata; w_strb_q <= axi.wstrb; axi.wready <= (w_dly == 0); w_cnt <= 0;
      end else if (axi.wvalid) begin
        if (w_cnt + 1 >= w_dly) axi.wready <= 1'b1; else w_cnt <= w_cnt + 1;
      end else axi.wready <= (w_dly == 0);

      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      else if (aw_got && w_got && !axi.bvalid) begin
        aw_got <= 1'b0; w_got <= 1'b0; axi.bvalid <= 1'b1; wr_count <= wr_count + 1;
        if (mapped(aw_addr_q)) begin
          for (int b = 0; b < DW/8; b++)
            if (w_strb_q[b]) mem[aw_addr_q[3:2]][b*8 +: 8] <= w_data_q[b*8 +: 8];
          axi.bresp <= 2'b00;
        end else axi.bresp <= 2'b10;
      end

      if (axi.arvalid && axi.arready) begin
        ar_got <= 1'b1; ar_addr_q <= axi.araddr; axi.arready <= (ar_dly == 0 && !ar_never); ar_cnt <= 0;
      end else if (axi.arvalid) begin
        if (!ar_never) begin
          if (ar_cnt + 1 >= ar_dly) axi.arready <= 1'b1; else ar_cnt <= ar_cnt + 1;
        end
      end else axi.arready <= (ar_dly == 0 && !ar_never);

      if (axi.rvalid && axi.rready) begin
        axi.rvalid <= 1'b0; ar_got <= 1'b0; r_cnt <= 0;
      end else if (ar_got && !axi.rvalid) begin
        if (r_cnt + 1 >= r_dly) begin
          axi.rvalid <= 1'b1;
          axi.rdata  <= mapped(ar_addr_q) ? mem[ar_addr_q[3:2]] : '0;
          axi.rresp  <= mapped(ar_addr_q) ? 2'b00 : 2'b10;
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  int cyc = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0, r_hs_cyc = 0;
  int viol = 0;
  bit mon_en = 1'b1;
  logic aw_stall = 1'b0, w_stall = 1'b0, ar_stall = 1'b0;
  logic aw_post = 1'b0, w_post = 1'b0, ar_post = 1'b0;
  logic [AW-1:0] aw_addr_s, ar_addr_s;
  logic [DW-1:0] w_data_s;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0;
      aw_post = 1'b0; w_post = 1'b0; ar_post = 1'b0;
    end else begin
      if (mon_en) begin
        if (aw_stall && (axi.awvalid !== 1'b1 || axi.awaddr !== aw_addr_s)) viol++;
        if (w_stall && (axi.wvalid !== 1'b1 || axi.wdata !== w_data_s)) viol++;
        if (ar_stall && (axi.arvalid !== 1'b1 || axi.araddr !== ar_addr_s)) viol++;
        if (aw_post && axi.awvalid) viol++;
        if (w_post && axi.wvalid) viol++;
        if (ar_post && axi.arvalid) viol++;
      end
      aw_stall = axi.awvalid && !axi.awready; aw_addr_s = axi.awaddr;
      w_stall  = axi.wvalid && !axi.wready;   w_data_s  = axi.wdata;
      ar_stall = axi.arvalid && !axi.arready; ar_addr_s = axi.araddr;
      aw_post  = axi.awvalid && axi.awready;
      w_post   = axi.wvalid && axi.wready;
      ar_post  = axi.arvalid && axi.arready;
      if (axi.awvalid && axi.awready) begin aw_hs++; aw_hs_cyc = cyc; end
      if (axi.wvalid && axi.wready)   begin w_hs++;  w_hs_cyc = cyc;  end
      if (axi.bvalid && axi.bready)   b_hs++;
      if (axi.arvalid && axi.arready) ar_hs++;
      if (axi.rvalid && axi.rready)   begin r_hs++;  r_hs_cyc = cyc;  end
    end
    cyc++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input cmd_t c);
    int n = 0;
    cmd_valid = 1'b1; cmd_is_wr = c.is_wr; cmd_addr = c.addr[AW-1:0];
    cmd_wdata = c.wdata[DW-1:0]; cmd_wstrb = c.wstrb[DW/8-1:0];
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("cmd_ready_wait", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  int rsp_cyc = 0;

  task automatic get_rsp(input string tag, input logic [1:0] e_resp, input logic [DW-1:0] e_data,
                         input logic e_to, input int hold);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    rsp_cyc = cyc;
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_resp"}, rsp_resp, e_resp);
    check({tag, "_rdata"}, rsp_rdata, e_data);
    check({tag, "_timeout"}, rsp_timeout, e_to);
    check({tag, "_cmd_ready_busy"}, cmd_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, rsp_valid, 1'b1);
      check({tag, "_hold_rdata"}, rsp_rdata, e_data);
      check({tag, "_hold_resp"}, rsp_resp, e_resp);
      check({tag, "_hold_cmd_ready"}, cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_dropped"}, rsp_valid, 1'b0);
    check({tag, "_cmd_ready_back"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int wr0, aw0, w0, b0, n;
    bit saw_rsp;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awvalid", axi.awvalid, 1'b0);
    check("rst_wvalid", axi.wvalid, 1'b0);
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_bready", axi.bready, 1'b0);
    check("rst_rready", axi.rready, 1'b0);
    check("rst_awaddr", axi.awaddr, 4'h0);
    check("rst_wdata", axi.wdata, 32'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_resp", rsp_resp, 2'b00);
    check("rst_rsp_timeout", rsp_timeout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);

    // Write 0x4 with immediate-ready slave: AW and W together.
    wr0 = wr_count; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    send(cmd_t'{1'b1, 32'h4, 64'hDEADBEEF, 8'hF});
    check("w1_awvalid", axi.awvalid, 1'b1);
    check("w1_wvalid", axi.wvalid, 1'b1);
    check("w1_awaddr", axi.awaddr, 4'h4);
    check("w1_wdata", axi.wdata, 32'hDEADBEEF);
    check("w1_wstrb", axi.wstrb, 4'hF);
    check("w1_awprot", axi.awprot, 3'b000);
    check("w1_cmd_ready", cmd_ready, 1'b0);
    get_rsp("w1", 2'b00, 32'h0, 1'b0, 0);
    check("w1_same_cycle", aw_hs_cyc, w_hs_cyc);
    check("w1_aw_count", aw_hs - aw0, 1);
    check("w1_w_count", w_hs - w0, 1);
    check("w1_b_count", b_hs - b0, 1);
    check("w1_slave_writes", wr_count - wr0, 1);

    send(cmd_t'{1'b0, 32'h4, 64'h0, 8'h0});
    check("r1_arvalid", axi.arvalid, 1'b1);
    check("r1_araddr", axi.araddr, 4'h4);
    check("r1_arprot", axi.arprot, 3'b000);
    get_rsp("r1", 2'b00, 32'hDEADBEEF, 1'b0, 0);

    // W completes first, AW three cycles later.
    wr0 = wr_count; aw_dly = 3; w_dly = 0;
    send(cmd_t'{1'b1, 32'h0, 64'h12345678, 8'hF});
    check("w2_c1_awvalid", axi.awvalid, 1'b1);
    check("w2_c1_wvalid", axi.wvalid, 1'b1);
    @(negedge clk);
    check("w2_c2_awvalid", axi.awvalid, 1'b1);
    check("w2_c2_wvalid", axi.wvalid, 1'b0);
    get_rsp("w2", 2'b00, 32'h0, 1'b0, 0);
    check("w2_aw_after_w", aw_hs_cyc - w_hs_cyc, 3);
    check("w2_slave_writes", wr_count - wr0, 1);

    // AW completes first, W two cycles later; upper-half strobes only.
    wr0 = wr_count; aw_dly = 0; w_dly = 2;
    send(cmd_t'{1'b1, 32'h4, 64'hA5A50000, 8'hC});
    @(negedge clk);
    check("w3_c2_awvalid", axi.awvalid, 1'b0);
    check("w3_c2_wvalid", axi.wvalid, 1'b1);
    get_rsp("w3", 2'b00, 32'h0, 1'b0, 0);
    check("w3_w_after_aw", w_hs_cyc - aw_hs_cyc, 2);
    check("w3_slave_writes", wr_count - wr0, 1);
    w_dly = 0;

    // Slow read, response held off for four cycles.
    ar_dly = 2; r_dly = 5;
    send(cmd_t'{1'b0, 32'h4, 64'h0, 8'h0});
    get_rsp("r2", 2'b00, 32'hA5A5BEEF, 1'b0, 4);
    check("r2_latency", rsp_cyc - r_hs_cyc, 1);
    ar_dly = 0; r_dly = 0;
    send(cmd_t'{1'b0, 32'h0, 64'h0, 8'h0});
    get_rsp("r3", 2'b00, 32'h12345678, 1'b0, 0);

    // Unmapped write returns SLVERR; the next commands proceed normally.
    send(cmd_t'{1'b1, 32'hC, 64'h11111111, 8'hF});
    get_rsp("w4_slverr", 2'b10, 32'h0, 1'b0, 0);
    send(cmd_t'{1'b1, 32'h8, 64'hCAFEF00D, 8'hF});
    get_rsp("w5", 2'b00, 32'h0, 1'b0, 0);
    send(cmd_t'{1'b0, 32'h8, 64'h0, 8'h0});
    get_rsp("r4", 2'b00, 32'hCAFEF00D, 1'b0, 0);

    // Reset while stalled in WR_REQ.
    wr0 = wr_count; aw_dly = 5; w_dly = 5;
    send(cmd_t'{1'b1, 32'h0, 64'h55555555, 8'hF});
    check("rst_mid_awvalid_before", axi.awvalid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_awvalid", axi.awvalid, 1'b0);
    check("rst_mid_wvalid", axi.wvalid, 1'b0);
    check("rst_mid_bready", axi.bready, 1'b0);
    check("rst_mid_arvalid", axi.arvalid, 1'b0);
    check("rst_mid_rready", axi.rready, 1'b0);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    rst_n = 1'b1;
    aw_dly = 0; w_dly = 0;
    @(negedge clk);
    check("rst_mid_cmd_ready", cmd_ready, 1'b1);
    saw_rsp = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("rst_mid_no_rsp", saw_rsp, 1'b0);
    check("rst_mid_no_write", wr_count - wr0, 0);
    send(cmd_t'{1'b0, 32'h0, 64'h0, 8'h0});
    get_rsp("r5", 2'b00, 32'h12345678, 1'b0, 0);

`ifdef MY_AXI4_LITE_MST_TIMEOUT_EN
    // Slave never accepts AR: watchdog aborts after TO cycles.
    mon_en = 1'b0; ar_never = 1'b1;
    send(cmd_t'{1'b0, 32'h0, 64'h0, 8'h0});
    n = 0;
    while (axi.arvalid === 1'b1 && n < 100) begin n++; @(negedge clk); end
    check("to_arvalid_cycles", n, TO);
    check("to_arvalid_low", axi.arvalid, 1'b0);
    get_rsp("to", 2'b11, 32'h0, 1'b1, 0);
    ar_never = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
`else
    n = 0;
`endif

    check("protocol_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
